// File: rtl/mac_issue_ctrl_pkg.sv
// Shared encodings, state enum and pipeline constants for the MAC column issuer.
package mac_issue_ctrl_pkg;

    // Instruction encodings driven into column 0 (2'b11 is never issued)
    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    // Cycles from a column's instruction to its fifo_wr
    localparam int COL_PIPE_DEPTH = 6;

    // Width of the sequence counters (n_query is 0..255, col fits as well)
    localparam int SEQ_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    // Instruction type carried by a read issued in the given state
    function automatic logic [1:0] issue_inst(input state_e st);
        logic [1:0] code;
        case (st)
            ST_LOAD: code = INST_LOAD;
            ST_EXEC: code = INST_EXEC;
            default: code = INST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mac_issue_addr_gen.sv
// Base + index address sequencer, shared by the key and query phases.
// Addresses wrap modulo 2^addr_bw; last flags the final index of the sequence.
module mac_issue_addr_gen
    import mac_issue_ctrl_pkg::*;
#(
    parameter int addr_bw = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [addr_bw-1:0]   base,
    input  logic [SEQ_CNT_W-1:0] limit,
    input  logic                 step,
    output logic [addr_bw-1:0]   addr,
    output logic                 last
);

    logic [addr_bw-1:0]   base_r;
    logic [SEQ_CNT_W-1:0] limit_r;
    logic [SEQ_CNT_W-1:0] cnt_r;
    logic [SEQ_CNT_W-1:0] cnt_nxt_s;

    // Base/limit capture on load, index advance on each issued read
    always_ff @(posedge clk) begin
        if (!reset) begin
            base_r  <= '0;
            limit_r <= {SEQ_CNT_W{1'b0}};
            cnt_r   <= {SEQ_CNT_W{1'b0}};
        end else if (load) begin
            base_r  <= base;
            limit_r <= limit;
            cnt_r   <= {SEQ_CNT_W{1'b0}};
        end else if (step) begin
            cnt_r   <= cnt_nxt_s;
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    assign cnt_nxt_s = cnt_r + {{(SEQ_CNT_W-1){1'b0}}, 1'b1};
    assign addr      = base_r + addr_bw'(cnt_r);
    assign last      = (cnt_nxt_s == limit_r);

endmodule

// File: rtl/mac_issue_ctrl.sv
// Issuer at the head of the MAC column chain: one key load per reset, then
// query execute bursts throttled by ofifo_ready, then a drain until the last
// column has written its output FIFO.
module mac_issue_ctrl
    import mac_issue_ctrl_pkg::*;
#(
    parameter int bw      = 8,
    parameter int pr      = 8,
    parameter int col     = 8,
    parameter int addr_bw = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] key_base,
    input  logic [addr_bw-1:0] q_base,
    input  logic [7:0]         n_query,
    input  logic               ofifo_ready,
    output logic               mem_cen,
    output logic [addr_bw-1:0] mem_addr,
    input  logic [pr*bw-1:0]   mem_rdata,
    output logic [1:0]         inst,
    output logic [pr*bw-1:0]   q_out,
    output logic               busy,
    output logic               done
);

    localparam int                   DRAIN_LEN  = col + COL_PIPE_DEPTH;
    localparam logic [15:0]          DRAIN_LAST = 16'(DRAIN_LEN - 1);
    localparam logic [SEQ_CNT_W-1:0] KEY_COUNT  = SEQ_CNT_W'(col);

    state_e               state_r;
    state_e               state_nxt_s;
    logic                 loaded_r;
    logic [addr_bw-1:0]   q_base_r;
    logic [7:0]           n_query_r;
    logic [15:0]          drain_cnt_r;
    logic                 done_r;
    logic [1:0]           inst_r;

    logic                 start_ok_s;
    logic                 issue_s;
    logic                 gen_load_s;
    logic [addr_bw-1:0]   gen_base_s;
    logic [SEQ_CNT_W-1:0] gen_limit_s;
    logic [addr_bw-1:0]   gen_addr_s;
    logic                 gen_last_s;

    // The cycle done is high is still treated as busy for start purposes
    assign start_ok_s = (state_r == ST_IDLE) && start && !done_r;

    mac_issue_addr_gen #(
        .addr_bw (addr_bw)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (gen_load_s),
        .base  (gen_base_s),
        .limit (gen_limit_s),
        .step  (issue_s),
        .addr  (gen_addr_s),
        .last  (gen_last_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start_ok_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (!loaded_r) begin
                    state_nxt_s = ST_LOAD;
                end else if (n_query == 8'd0) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_LOAD: begin
                if (!gen_last_s) begin
                    state_nxt_s = ST_LOAD;
                end else if (n_query_r == 8'd0) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (issue_s && gen_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read issue and address-sequencer control; ofifo_ready acts in the issue cycle
    always_comb begin
        issue_s     = 1'b0;
        gen_load_s  = 1'b0;
        gen_base_s  = key_base;
        gen_limit_s = KEY_COUNT;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s && loaded_r) begin
                    gen_load_s  = 1'b1;
                    gen_base_s  = q_base;
                    gen_limit_s = n_query;
                end else if (start_ok_s) begin
                    gen_load_s  = 1'b1;
                    gen_base_s  = key_base;
                    gen_limit_s = KEY_COUNT;
                end else begin
                    gen_load_s  = 1'b0;
                end
            end
            ST_LOAD: begin
                issue_s = 1'b1;
                if (gen_last_s) begin
                    gen_load_s  = 1'b1;
                    gen_base_s  = q_base_r;
                    gen_limit_s = n_query_r;
                end else begin
                    gen_load_s  = 1'b0;
                end
            end
            ST_EXEC:  issue_s = ofifo_ready;
            ST_DRAIN: issue_s = 1'b0;
            default:  issue_s = 1'b0;
        endcase
    end

    // Run parameters, load flag, drain counter, done pulse and instruction register
    always_ff @(posedge clk) begin
        if (!reset) begin
            loaded_r    <= 1'b0;
            q_base_r    <= '0;
            n_query_r   <= 8'd0;
            drain_cnt_r <= 16'd0;
            done_r      <= 1'b0;
            inst_r      <= INST_IDLE;
        end else begin
            if (start_ok_s) begin
                q_base_r  <= q_base;
                n_query_r <= n_query;
            end
            if ((state_r == ST_LOAD) && gen_last_s) begin
                loaded_r <= 1'b1;
            end
            if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + 16'd1;
            end else begin
                drain_cnt_r <= 16'd0;
            end
            done_r <= (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_LAST);
            inst_r <= issue_s ? issue_inst(state_r) : INST_IDLE;
        end
    end

    // The SRAM output register holds the operand; it is forwarded only alongside a live instruction
    assign q_out    = (inst_r != INST_IDLE) ? mem_rdata : '0;
    assign inst     = inst_r;
    assign mem_cen  = ~issue_s;
    assign mem_addr = issue_s ? gen_addr_s : '0;
    assign busy     = (state_r != ST_IDLE);
    assign done     = done_r;

endmodule
